// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Optional subtract mode is enabled by defining SUBTRACT_EN.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int SLICE_W = 4;

  // Nibble counter width for a given operand width (N = width/4 nibbles).
  function automatic int nsa_cnt_w(input int width);
    int n;
    n = width / SLICE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit ripple-carry slice shared across all nibble cycles.
module nibble_slice_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add through one shared 4-bit slice, LS nibble first, N=WIDTH/4 cycles.
// Define SUBTRACT_EN to add the sub port (a - b via ~b + 1).
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = nsa_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  nsa_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, sacc, sacc_nxt;
  logic             carry, a_msb, b_msb;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic             accept, step, last;
  logic [SLICE_W-1:0] s_nib;
  logic             s_co;

  always_comb begin
    beff = b;
    ceff = cin;
`ifdef SUBTRACT_EN
    if (sub) begin
      beff = ~b;
      ceff = 1'b1;
    end
`endif
  end

  nibble_slice_adder u_slice (
    .a  (a_sr[SLICE_W-1:0]),
    .b  (b_sr[SLICE_W-1:0]),
    .ci (carry),
    .s  (s_nib),
    .co (s_co)
  );

  // Slice result enters at the top; after N steps nibble 0 has reached the bottom.
  assign sacc_nxt = {s_nib, {(WIDTH-SLICE_W){1'b0}}} | (sacc >> SLICE_W);
  assign last     = (cnt == LAST);

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      sacc  <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      a_sr  <= a;
      b_sr  <= beff;
      sacc  <= '0;
      carry <= ceff;
      a_msb <= a[WIDTH-1];
      b_msb <= beff[WIDTH-1];
    end else if (step) begin
      a_sr  <= a_sr >> SLICE_W;
      b_sr  <= b_sr >> SLICE_W;
      sacc  <= sacc_nxt;
      carry <= s_co;
      if (!last) cnt <= cnt + 1'b1;
      // Visible outputs only move on the final nibble edge.
      if (last) begin
        sum  <= sacc_nxt;
        cout <= s_co;
        ovf  <= (a_msb == b_msb) && (sacc_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed-vector bench for nibble_serial_adder_ctrl (WIDTH=16, N=4).
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int vecs = 0;
  int errs = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SUBTRACT_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({start_ready, res_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_state got rdy=%b vld=%b sum=%h cout=%b ovf=%b want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               start_ready, res_valid, sum, cout, ovf);
    end
  endtask

  // Accept one operation, check latency, result and return to IDLE.
  task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input logic [W-1:0] es,
                        input logic ec, input logic eo, input bit release_now);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is;
    start_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    vecs++;
    if (start_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s run_ready got %b want 0", nm, start_ready);
    end
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (res_valid !== (k == N)) begin
        errs++;
        $display("FAIL %s latency cycle %0d res_valid got %b want %b", nm, k, res_valid, (k == N));
      end
    end
    vecs++;
    if ({sum, cout, ovf} !== {es, ec, eo}) begin
      errs++;
      $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, es, ec, eo);
    end
    if (release_now) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      vecs++;
      if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
        errs++;
        $display("FAIL %s back_to_idle got rdy=%b vld=%b want rdy=1 vld=0", nm, start_ready, res_valid);
      end
    end
  endtask

  task automatic test_basic();
    run_op("add_1234_1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_carry_ovf();
    run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op("zero_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_op("8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_op("bp_a5a5", 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_valid = ~start_valid;
      a = 16'h1111 * k[15:0]; b = 16'h7777;
      @(posedge clk); #1;
      vecs++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || {sum, cout, ovf} !== {16'hB4B4, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=b4b4 cout=0 ovf=0",
                 k, res_valid, start_ready, sum, cout, ovf);
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vecs++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || sum !== 16'hB4B4) begin
      errs++;
      $display("FAIL bp_release got rdy=%b vld=%b sum=%h want rdy=1 vld=0 sum=b4b4", start_ready, res_valid, sum);
    end
    run_op("bp_next", 16'h0102, 16'h0304, 1'b1, 1'b0, 16'h0407, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({start_ready, res_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h cout=%b ovf=%b want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               start_ready, res_valid, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 1; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (res_valid !== 1'b0 || sum !== 16'h0) begin
        errs++;
        $display("FAIL midrun_no_result cyc %0d got vld=%b sum=%h want vld=0 sum=0000", k, res_valid, sum);
      end
    end
    run_op("after_reset", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract();
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    run_op("sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_reset_mid_run();
`ifdef SUBTRACT_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that performs a WIDTH-bit add by pushing operands through a single shared 4-bit ripple-carry slice, one nibble per clock, least-significant nibble first. It sits between a requester with a valid/ready operand interface and a consumer with a valid/ready result interface. It owns the nibble counter, the inter-nibble carry register and the result assembly. This trades latency for area versus a full-width ripple adder.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operands a, b, cin (and sub) are valid
- start_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to nibble 0
- sub  in  1  subtract request; present only with SUBTRACT_EN
- res_valid  out  1  sum, cout and ovf are valid
- res_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement signed overflow

## Operation
- N = WIDTH/4 nibbles. FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready, latch a into A-shift register, effective b into B-shift register, carry register <= effective cin, latch MSBs of a and effective b, clear nibble counter, go to RUN.
- RUN: slice adds A[3:0], B[3:0], carry. Slice sum shifts into the top nibble of the sum register (sum shifts right 4); A and B shift right 4; carry register <= slice carry-out; counter increments. After processing nibble N-1, go to DONE.
- DONE: res_valid=1; sum, cout = final carry, ovf = (a_msb == beff_msb) && (sum[WIDTH-1] != a_msb). Outputs held stable while res_ready=0. On res_ready, go to IDLE.
- start_ready=0 in RUN and DONE; start_valid is ignored there and operands are not sampled.
- Counter width clog2(N); no wrap beyond N-1.
- Reset is asynchronous at any time, including mid-RUN: state to IDLE. All registers, including sum, cout, ovf, res_valid and the counter, to 0. Partial results are discarded. No result is emitted for the interrupted operation.
- Reset values: start_ready=1 after reset is released; res_valid=0; sum=0; cout=0; ovf=0.

## Timing
- Accept edge E0: IDLE to RUN. Edges E1..EN each process one nibble. At EN the state becomes DONE.
- res_valid is high in the cycle after EN, so latency is N cycles from accept edge to res_valid (4 cycles for WIDTH=16).
- Result handshake completes at the edge where res_valid&&res_ready. The state is IDLE on the next cycle.
- Minimum issue interval is N+2 cycles: no overlap and no bypass from DONE to RUN.
- sum, cout and ovf are registered outputs. They change only at EN or at reset.

## Configuration
- SUBTRACT_EN defined:
  - The sub port exists.
  - When sub=1 at accept, effective b = ~b and effective cin = 1; the cin port is ignored.
  - cout=1 means no borrow.
  - ovf uses the effective b MSB.
- SUBTRACT_EN undefined:
  - There is no sub port.
  - Effective b = b and effective cin = cin; add only.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, RUN, DONE)
  - slice width constant (4)
  - the function computing the counter width from WIDTH
- One sub-module, nibble_slice_adder:
  - pure combinational 4-bit ripple add with carry in and carry out
  - instantiated once and shared across all nibble cycles

## Test plan
- Reset: hold rst_n=0, then release -> start_ready=1, res_valid=0, sum=0, cout=0, ovf=0; assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately.
- Basic add (WIDTH=16): a=0x1234, b=0x1111, cin=0 -> res_valid exactly 4 cycles after accept, sum=0x2345, cout=0, ovf=0.
- Carry ripple and overflow:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x0000+0x0000 with cin=1 -> sum=0x0001.
- Backpressure: hold res_ready=0 for 3 cycles in DONE while toggling start_valid -> sum, cout and ovf stable, start_ready=0, no new operands taken; raise res_ready -> IDLE next cycle, next operation correct.
- Reset mid-RUN: assert rst_n after 2 nibbles of 0xABCD+0x1111 -> IDLE, all outputs 0, no res_valid; the following 0x0001+0x0002 gives 0x0003.
- SUBTRACT_EN:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
